// File: rtl/contador_bcd_multi.sv
// -----------------------------------------------------------------------------
// contador_bcd_multi
//
// Multi-digit BCD up/down counter with a synchronous preset load, a one-cycle
// wrap pulse, and a free-running time-multiplexed 7-segment scanner.
//
// Parameters
//    DIGITS    number of BCD digits (1..8)
//    SCAN_DIV  clk cycles each digit stays strobed (>= 1)
//    DP_POS    digit index whose decimal point lights; >= DIGITS lights none
//
// Ports
//    clk       in   rising-edge clock
//    rst       in   synchronous reset, active-high
//    en        in   count enable, one step per clk when high
//    up        in   1 = increment, 0 = decrement
//    load      in   synchronous preset strobe (wins over en)
//    load_val  in   BCD preset, digit 0 in [3:0]; digits > 9 saturate to 9
//    cont      out  current BCD count, registered
//    dp        out  wrap pulse, registered, high for one cycle
//    out       out  segments {dp,g,f,e,d,c,b,a}, active-high
//    an        out  one-hot digit strobe, active-high
//
// Build option
//    CONTADOR_LZB_EN  when defined, digits above the most significant
//                     nonzero digit are blanked (digit 0 is never blanked).
// -----------------------------------------------------------------------------
module contador_bcd_multi #(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned SCAN_DIV = 4,
   parameter int unsigned DP_POS   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   cont,
   output logic                  dp,
   output logic [7:0]            out,
   output logic [DIGITS-1:0]     an
);

   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

   logic [4*DIGITS-1:0] cont_q, cont_d;
   logic                dp_q, dp_d;
   logic [PW-1:0]       presc_q, presc_d;
   logic [IW-1:0]       idx_q, idx_d;

   // 7-segment code for one BCD digit, {g,f,e,d,c,b,a}.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   // Counter next state. The ripple carry/borrow enters digit 0 as 1; if it
   // survives past the top digit the whole counter wrapped.
   always_comb begin
      logic       carry;
      logic [3:0] d;
      logic [3:0] nd;
      cont_d = cont_q;
      dp_d   = 1'b0;
      carry  = 1'b0;
      d      = 4'd0;
      nd     = 4'd0;
      if (load) begin
         for (int i = 0; i < int'(DIGITS); i++) begin
            d = load_val[4*i +: 4];
            cont_d[4*i +: 4] = (d > 4'd9) ? 4'd9 : d;
         end
      end else if (en) begin
         carry = 1'b1;
         for (int i = 0; i < int'(DIGITS); i++) begin
            d  = cont_q[4*i +: 4];
            nd = d;
            if (carry) begin
               if (up) begin
                  if (d == 4'd9) begin
                     nd = 4'd0;
                  end else begin
                     nd    = d + 4'd1;
                     carry = 1'b0;
                  end
               end else begin
                  if (d == 4'd0) begin
                     nd = 4'd9;
                  end else begin
                     nd    = d - 4'd1;
                     carry = 1'b0;
                  end
               end
            end
            cont_d[4*i +: 4] = nd;
         end
         dp_d = carry;
      end
   end

   // Scanner next state: free-running, independent of en/load.
   always_comb begin
      presc_d = presc_q + PW'(1);
      idx_d   = idx_q;
      if (presc_q == PRESC_MAX) begin
         presc_d = '0;
         idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cont_q  <= '0;
         dp_q    <= 1'b0;
         presc_q <= '0;
         idx_q   <= '0;
      end else begin
         cont_q  <= cont_d;
         dp_q    <= dp_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
      end
   end

   assign cont = cont_q;
   assign dp   = dp_q;

   // Display outputs come straight from registered state, so a count change
   // shows on the segments in the same cycle cont changes.
   always_comb begin
      logic [3:0]        digit;
      logic [DIGITS-1:0] blank;
      logic              zero_above;
      digit      = 4'd0;
      blank      = '0;
      zero_above = 1'b1;
      an         = '0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (idx_q == IW'(i)) begin
            digit = cont_q[4*i +: 4];
            an[i] = 1'b1;
         end
      end
`ifdef CONTADOR_LZB_EN
      // Walk down from the top digit; a digit is blanked while every digit
      // at or above it is zero. Digit 0 is left out so zero still shows.
      for (int i = int'(DIGITS) - 1; i > 0; i--) begin
         zero_above = zero_above & (cont_q[4*i +: 4] == 4'd0);
         blank[i]   = zero_above;
      end
`else
      zero_above = 1'b0;
`endif
      out[6:0] = 7'h00;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (idx_q == IW'(i)) begin
            out[6:0] = blank[i] ? 7'h00 : seg7(digit);
         end
      end
      out[7] = (32'(idx_q) == DP_POS);
   end

endmodule
